// File: rtl/stream_fifo_if.sv
// Handshake bundle for stream_fifo: upstream push side, downstream pop side
// and occupancy status. The FIFO binds the slave modport; the producer and
// consumer side binds master.
interface stream_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, count_o, full_o, empty_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/stream_fifo.sv
// Circular-buffer stream FIFO with a registered ready_o, an optional
// write-side payload transform and a 1-cycle minimum fall-through latency.
// The head entry is read straight from storage. There is no input-to-output
// bypass.
module stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0
) (
  input logic           clk,
  input logic           rst_n,
  stream_fifo_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              ready_q;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic [DATA_W-1:0] wdata;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty = (count != '0);
  assign push      = bus.valid_i && ready_q;
  assign pop       = not_empty && bus.ready_i;

  // Payload transform applied before the payload is stored.
  always_comb begin
    wdata = bus.data_i;
    case (MODE)
      1:       wdata = ~bus.data_i;
      2:       wdata = bus.data_i + DATA_W'(1);
      default: wdata = bus.data_i;
    endcase
  end

  // Occupancy after this edge. A simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  // Pointers, occupancy and the registered ready all clear asynchronously.
  // Ready comes up on the first live edge, so that edge never accepts a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      count   <= count_next;
      ready_q <= (count_next != CNT_W'(DEPTH));
    end
  end

  // Storage is not reset. Only written entries are ever presented.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = not_empty;
  assign bus.empty_o = !not_empty;
  assign bus.full_o  = (count == CNT_W'(DEPTH));
  assign bus.count_o = count;
  assign bus.data_o  = not_empty ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed reset, fill/drain, streaming,
// transform and mid-transfer reset cases, then randomized stalls on a
// 5-deep, 12-bit instance checked against a queue model.
module tb_stream_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  stream_fifo_if #(.DATA_W(8),  .DEPTH(4)) bus0();
  stream_fifo_if #(.DATA_W(8),  .DEPTH(4)) bus1();
  stream_fifo_if #(.DATA_W(8),  .DEPTH(4)) bus2();
  stream_fifo_if #(.DATA_W(12), .DEPTH(5)) bus3();

  stream_fifo #(.DATA_W(8),  .DEPTH(4), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  stream_fifo #(.DATA_W(8),  .DEPTH(4), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  stream_fifo #(.DATA_W(8),  .DEPTH(4), .MODE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  stream_fifo #(.DATA_W(12), .DEPTH(5), .MODE(0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Reference model: contents as a queue, plus the ready the consumer should
  // see, which reflects occupancy at the previous edge.
  logic [7:0]  q0[$];
  bit          exp_rdy0 = 1'b0;
  logic [11:0] q3[$];
  bit          exp_rdy3 = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic checkAll0(input string tag);
    checkOutput({tag, "_cnt"},   32'(bus0.count_o), 32'(q0.size()));
    checkOutput({tag, "_valid"}, 32'(bus0.valid_o), 32'(q0.size() != 0));
    checkOutput({tag, "_empty"}, 32'(bus0.empty_o), 32'(q0.size() == 0));
    checkOutput({tag, "_full"},  32'(bus0.full_o),  32'(q0.size() == 4));
    checkOutput({tag, "_ready"}, 32'(bus0.ready_o), 32'(exp_rdy0));
    if (q0.size() != 0)
      checkOutput({tag, "_data"}, 32'(bus0.data_o), 32'(q0[0]));
  endtask

  // One clock of traffic on the 4-deep pass-through instance. The caller is
  // just past a rising edge; outputs are checked just past the next one.
  task automatic applyStimulus0(input string tag, input bit v, input logic [7:0] d,
                                input bit r, output bit pushed);
    bit pop;
    bus0.valid_i = v;
    bus0.data_i  = d;
    bus0.ready_i = r;
    pushed = v && exp_rdy0;
    pop    = r && (q0.size() != 0);
    @(posedge clk);
    #1;
    if (pop)
      void'(q0.pop_front());
    if (pushed)
      q0.push_back(d);
    exp_rdy0 = (q0.size() != 4);
    checkAll0(tag);
  endtask

  initial begin
    bit          pushed;
    bit          held;
    int          idx;
    int          popped;
    int          sent;
    int          cycles;
    bit          v3;
    bit          r3;
    bit          pop3;
    bit          push3;
    logic [11:0] hold3;

    bus0.valid_i = 0; bus0.data_i = '0; bus0.ready_i = 0;
    bus1.valid_i = 0; bus1.data_i = '0; bus1.ready_i = 0;
    bus2.valid_i = 0; bus2.data_i = '0; bus2.ready_i = 0;
    bus3.valid_i = 0; bus3.data_i = '0; bus3.ready_i = 0;

    // Values held while reset is asserted.
    #2;
    checkOutput("rst_ready", 32'(bus0.ready_o), 32'd0);
    checkOutput("rst_valid", 32'(bus0.valid_o), 32'd0);
    checkOutput("rst_cnt",   32'(bus0.count_o), 32'd0);
    checkOutput("rst_empty", 32'(bus0.empty_o), 32'd1);
    checkOutput("rst_full",  32'(bus0.full_o),  32'd0);
    checkOutput("rst_data",  32'(bus0.data_o),  32'd0);

    // Release; the first live edge raises ready and accepts nothing.
    @(negedge clk);
    rst_n = 1'b1;
    bus0.valid_i = 1'b1;
    bus0.data_i  = 8'hEE;
    #1;
    checkOutput("rel_ready_before", 32'(bus0.ready_o), 32'd0);
    @(posedge clk);
    #1;
    bus0.valid_i = 1'b0;
    exp_rdy0 = 1'b1;
    checkAll0("rel_first_edge");

    // Fill to full with the consumer stalled, then offer a fifth payload.
    applyStimulus0("fill1", 1, 8'h11, 0, pushed);
    applyStimulus0("fill2", 1, 8'h22, 0, pushed);
    applyStimulus0("fill3", 1, 8'h33, 0, pushed);
    applyStimulus0("fill4", 1, 8'h44, 0, pushed);
    checkOutput("fill_full", 32'(bus0.full_o), 32'd1);
    applyStimulus0("hold5a", 1, 8'h55, 0, pushed);
    checkOutput("hold5a_accepted", 32'(pushed), 32'd0);
    applyStimulus0("hold5b", 1, 8'h55, 0, pushed);
    checkOutput("hold5b_cnt", 32'(bus0.count_o), 32'd4);

    // Drain, with the upstream holding 0x55 until it is taken.
    held = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus0("drain", held, 8'h55, 1, pushed);
      if (pushed)
        held = 1'b0;
    end
    checkOutput("drain_empty", 32'(bus0.empty_o), 32'd1);
    checkOutput("drain_55_taken", 32'(held), 32'd0);

    // Streaming 0..9 with both sides always ready.
    idx = 0;
    for (int i = 0; i < 30 && idx < 10; i++) begin
      applyStimulus0("stream", 1, 8'(idx), 1, pushed);
      if (pushed)
        idx++;
      checkOutput("stream_cnt1", 32'(bus0.count_o), 32'd1);
    end
    checkOutput("stream_all_sent", 32'(idx), 32'd10);
    applyStimulus0("stream_tail", 0, 8'h00, 1, pushed);
    checkOutput("stream_tail_empty", 32'(bus0.empty_o), 32'd1);

    // Write-side transforms.
    bus1.valid_i = 1'b1; bus1.data_i = 8'hA5;
    bus2.valid_i = 1'b1; bus2.data_i = 8'hFF;
    @(posedge clk);
    #1;
    bus1.valid_i = 1'b0;
    bus2.data_i  = 8'h7F;
    checkOutput("mode1_invert", 32'(bus1.data_o), 32'h5A);
    checkOutput("mode1_valid",  32'(bus1.valid_o), 32'd1);
    checkOutput("mode2_wrap",   32'(bus2.data_o), 32'h00);
    @(posedge clk);
    #1;
    bus2.valid_i = 1'b0;
    bus2.ready_i = 1'b1;
    checkOutput("mode2_cnt", 32'(bus2.count_o), 32'd2);
    @(posedge clk);
    #1;
    bus2.ready_i = 1'b0;
    checkOutput("mode2_inc", 32'(bus2.data_o), 32'h80);

    // Asynchronous reset with three entries held.
    applyStimulus0("pre_rst1", 1, 8'hAA, 0, pushed);
    applyStimulus0("pre_rst2", 1, 8'hBB, 0, pushed);
    applyStimulus0("pre_rst3", 1, 8'hCC, 0, pushed);
    bus0.valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(bus0.valid_o), 32'd0);
    checkOutput("async_cnt",   32'(bus0.count_o), 32'd0);
    checkOutput("async_ready", 32'(bus0.ready_o), 32'd0);
    checkOutput("async_data",  32'(bus0.data_o),  32'd0);
    q0.delete();
    exp_rdy0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_rdy0 = 1'b1;
    checkAll0("post_rst");
    applyStimulus0("post_rst_push", 1, 8'h99, 0, pushed);
    checkOutput("post_rst_data", 32'(bus0.data_o), 32'h99);
    applyStimulus0("post_rst_pop", 0, 8'h00, 1, pushed);
    checkOutput("post_rst_no_stale", 32'(bus0.valid_o), 32'd0);

    // Random stalls on the 5-deep, 12-bit instance; phases bias the consumer
    // so the FIFO reaches both full and empty repeatedly.
    exp_rdy3 = 1'b1;
    checkOutput("rand_start_ready", 32'(bus3.ready_o), 32'd1);
    popped = 0;
    sent   = 0;
    cycles = 0;
    v3     = 1'b0;
    hold3  = '0;
    while (popped < 1000 && cycles < 20000) begin
      if (!v3 && sent < 1000) begin
        v3    = ($urandom_range(0, 3) != 0);
        hold3 = 12'($urandom);
      end
      r3 = ((cycles / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 3) != 0);
      bus3.valid_i = v3;
      bus3.data_i  = hold3;
      bus3.ready_i = r3;
      push3 = v3 && exp_rdy3;
      pop3  = r3 && (q3.size() != 0);
      @(posedge clk);
      #1;
      cycles++;
      if (pop3) begin
        void'(q3.pop_front());
        popped++;
      end
      if (push3) begin
        q3.push_back(hold3);
        sent++;
        v3 = 1'b0;
      end
      exp_rdy3 = (q3.size() != 5);
      checkOutput("rand_cnt",   32'(bus3.count_o), 32'(q3.size()));
      checkOutput("rand_valid", 32'(bus3.valid_o), 32'(q3.size() != 0));
      checkOutput("rand_ready", 32'(bus3.ready_o), 32'(exp_rdy3));
      checkOutput("rand_full",  32'(bus3.full_o),  32'(q3.size() == 5));
      if (q3.size() != 0)
        checkOutput("rand_data", 32'(bus3.data_o), 32'(q3[0]));
    end
    bus3.valid_i = 1'b0;
    bus3.ready_i = 1'b0;
    checkOutput("rand_done", 32'(popped), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range >= 1.
REQ-002 Parameter DEPTH, default 4: number of storage entries, legal range >= 2, any integer value.
REQ-003 Parameter MODE, default 0: payload transform applied on write. 0 = pass-through, 1 = bitwise invert, 2 = increment modulo 2^DATA_W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 valid_i  input  1  upstream payload valid.
REQ-007 ready_o  output  1  block can accept a payload (registered).
REQ-008 data_i  input  DATA_W  upstream payload.
REQ-009 valid_o  output  1  downstream payload valid.
REQ-010 ready_i  input  1  downstream can accept a payload.
REQ-011 data_o  output  DATA_W  downstream payload (head entry).
REQ-012 count_o  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-013 full_o  output  1  high when count_o == DEPTH.
REQ-014 empty_o  output  1  high when count_o == 0.

Function
REQ-015 A push occurs on a rising edge where valid_i && ready_o; a pop occurs on a rising edge where valid_o && ready_i.
REQ-016 On a push, the transformed data_i per MODE is written at wr_ptr, and wr_ptr advances by 1, wrapping from DEPTH-1 to 0.
REQ-017 On a pop, rd_ptr advances by 1, wrapping from DEPTH-1 to 0.
REQ-018 count_o updates as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-019 ready_o is a register loaded every edge with (count_next != DEPTH); it never combinationally depends on ready_i.
REQ-020 When full, no push occurs even if a pop happens in the same cycle; ready_o rises on the edge after the pop.
REQ-021 valid_o = !empty_o and data_o = mem[rd_ptr]; data_o is X-free whenever valid_o is 1.
REQ-022 Latency: a payload pushed at edge N is visible on data_o with valid_o=1 after edge N when the FIFO was empty, so the minimum latency is 1 cycle. There is no combinational input-to-output bypass.
REQ-023 While valid_o && !ready_i, data_o and valid_o remain stable until the pop.
REQ-024 valid_i while ready_o=0 has no effect, so the payload is not lost or duplicated; the upstream holds it.
REQ-025 ready_i while empty has no effect; count_o never underflows below 0 or overflows above DEPTH.
REQ-026 Payloads exit in strict FIFO order across any number of pointer wraps.
REQ-027 The MODE 2 increment wraps all-ones to all-zeros, with no carry-out.

Reset
REQ-028 While rst_n=0, the following hold: ready_o=0, valid_o=0, count_o=0, empty_o=1, full_o=0, pointers=0, and data_o=0.
REQ-029 Assertion of rst_n takes effect immediately, without a clock, including mid-transfer; all held entries are discarded.
REQ-030 The first rising edge with rst_n=1 sets ready_o=1; no push is accepted on that edge.
REQ-031 The storage array contents need not be reset; because of REQ-021, the storage contents are never observable.

Verification
REQ-032 Reset release with DEPTH=4, MODE=0 -> ready_o=0 before the first edge and 1 after it; valid_o=0; count_o=0.
REQ-033 Fill with 0x11, 0x22, 0x33, 0x44 and ready_i=0 -> full_o=1, ready_o=0, count_o=4. A fifth push of 0x55 is held off. Then ready_i=1 -> output is 0x11, 0x22, 0x33, 0x44 in order, then 0x55.
REQ-034 Continuous valid_i/ready_i with 10 payloads 0..9 -> output 0..9 in order, count_o stays at 1 after the first push, and pointers wrap twice.
REQ-035 MODE=1 pushing 0xA5 -> data_o=0x5A. MODE=2 pushing 0xFF -> data_o=0x00, and pushing 0x7F -> data_o=0x80.
REQ-036 With 3 entries held, assert rst_n=0 mid-cycle -> valid_o=0 and count_o=0 immediately. After release and a push of 0x99, data_o=0x99, with no stale entries.
REQ-037 Random valid_i/ready_i stalls with DEPTH=5, DATA_W=12 for 1000 payloads -> a scoreboard matches in order, count_o never exceeds 5, and ready_o=0 iff count_o was 5 at the previous edge.
